seg7_scan_mux_n: RTL and testbench

//  Parametrised multiplexed 7-segment scan driver for the irrigation controller front panel; generalises the fixed 4-digit display mux.

---
 rtl/seg7_scan_mux_n.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_mux_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux_n.sv
// Multiplexed 7-segment scan driver for N_DIGITS digits.
// Shadow glyph bank written by the controller, copied into the active bank
// at frame boundaries on commit; blank interval at the start of each digit
// slot; whole-display blink while ERRO is high. All outputs active-low and
// registered.
module seg7_scan_mux_n #(
   parameter int N_DIGITS     = 4,
   parameter int DIV          = 50000,
   parameter int BLANK_CYC    = 64,
   parameter int BLINK_FRAMES = 25,
   parameter int IW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                wr_en,
   input  logic [IW-1:0]       wr_addr,
   input  logic [4:0]          wr_code,
   input  logic                wr_dp,
   input  logic                commit,
   input  logic                ERRO,
   output logic                busy,
   output logic                frame_start,
   output logic [6:0]          SEGs,
   output logic                SEG_P,
   output logic [N_DIGITS-1:0] SEG_D
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [4:0]    CODE_BLANK = 5'h10;

   // Active-low glyph lookup for segments a..g on bits 0..6.
   function automatic logic [6:0] glyph(input logic [4:0] code);
      logic [6:0] g;
      case (code)
         5'h00:   g = 7'h40;
         5'h01:   g = 7'h79;
         5'h02:   g = 7'h24;
         5'h03:   g = 7'h30;
         5'h04:   g = 7'h19;
         5'h05:   g = 7'h12;
         5'h06:   g = 7'h02;
         5'h07:   g = 7'h78;
         5'h08:   g = 7'h00;
         5'h09:   g = 7'h10;
         5'h0A:   g = 7'h08;
         5'h0B:   g = 7'h03;
         5'h0C:   g = 7'h46;
         5'h0D:   g = 7'h21;
         5'h0E:   g = 7'h06;
         5'h0F:   g = 7'h0E;
         5'h11:   g = 7'h3F;
         5'h12:   g = 7'h06;
         5'h13:   g = 7'h2F;
         default: g = 7'h7F;
      endcase
      return g;
   endfunction

   logic [PW-1:0]       pre_q, pre_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                busy_q, busy_d;
   logic                frame_start_q, frame_start_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                phase_q, phase_d;
   logic [4:0]          sh_code_q [N_DIGITS];
   logic [4:0]          sh_code_d [N_DIGITS];
   logic                sh_dp_q   [N_DIGITS];
   logic                sh_dp_d   [N_DIGITS];
   logic [4:0]          ac_code_q [N_DIGITS];
   logic [4:0]          ac_code_d [N_DIGITS];
   logic                ac_dp_q   [N_DIGITS];
   logic                ac_dp_d   [N_DIGITS];
   logic [6:0]          segs_q, segs_d;
   logic                seg_p_q, seg_p_d;
   logic [N_DIGITS-1:0] seg_d_q, seg_d_d;

   logic tick;
   logic frame_end;

   // Slot prescaler and digit index; frame_end marks the wrap back to digit 0.
   always_comb begin
      tick      = (pre_q == PRE_LAST);
      frame_end = tick && (idx_q == IDX_LAST);
      pre_d     = tick ? '0 : pre_q + 1'b1;
      idx_d     = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      frame_start_d = frame_end;
   end

   // Shadow writes, commit tracking and the atomic shadow->active copy.
   // The copy reads the pre-edge shadow, so a write in the boundary cycle
   // misses it; a commit in that cycle re-arms busy for the next frame.
   always_comb begin
      sh_code_d = sh_code_q;
      sh_dp_d   = sh_dp_q;
      ac_code_d = ac_code_q;
      ac_dp_d   = ac_dp_q;
      if (frame_end && busy_q) begin
         ac_code_d = sh_code_q;
         ac_dp_d   = sh_dp_q;
      end
      if (wr_en && (32'(wr_addr) < N_DIGITS)) begin
         sh_code_d[wr_addr] = wr_code;
         sh_dp_d[wr_addr]   = wr_dp;
      end
      if (commit) begin
         busy_d = 1'b1;
      end else if (frame_end) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
   end

   // Blink phase: toggles every BLINK_FRAMES frame boundaries while ERRO is high.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (!ERRO) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Output decode; ERRO gates the dark phase directly so a falling ERRO
   // restores the display on the very next register update.
   always_comb begin
      segs_d  = 7'h7F;
      seg_p_d = 1'b1;
      seg_d_d = '1;
      if (pre_q >= BLANK_END) begin
         seg_d_d[idx_q] = 1'b0;
         if (!(phase_q && ERRO)) begin
            segs_d  = glyph(ac_code_q[idx_q]);
            seg_p_d = ~ac_dp_q[idx_q];
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         pre_q         <= '0;
         idx_q         <= '0;
         busy_q        <= 1'b0;
         frame_start_q <= 1'b0;
         blink_cnt_q   <= '0;
         phase_q       <= 1'b0;
         segs_q        <= 7'h7F;
         seg_p_q       <= 1'b1;
         seg_d_q       <= '1;
         for (int unsigned i = 0; i < N_DIGITS; i++) begin
            sh_code_q[i] <= CODE_BLANK;
            sh_dp_q[i]   <= 1'b0;
            ac_code_q[i] <= CODE_BLANK;
            ac_dp_q[i]   <= 1'b0;
         end
      end else begin
         pre_q         <= pre_d;
         idx_q         <= idx_d;
         busy_q        <= busy_d;
         frame_start_q <= frame_start_d;
         blink_cnt_q   <= blink_cnt_d;
         phase_q       <= phase_d;
         segs_q        <= segs_d;
         seg_p_q       <= seg_p_d;
         seg_d_q       <= seg_d_d;
         sh_code_q     <= sh_code_d;
         sh_dp_q       <= sh_dp_d;
         ac_code_q     <= ac_code_d;
         ac_dp_q       <= ac_dp_d;
      end
   end

   assign busy        = busy_q;
   assign frame_start = frame_start_q;
   assign SEGs        = segs_q;
   assign SEG_P       = seg_p_q;
   assign SEG_D       = seg_d_q;

endmodule

// File: tb/tb_seg7_scan_mux_n.sv
// Bench for seg7_scan_mux_n (N_DIGITS=4, DIV=8, BLANK_CYC=2, BLINK_FRAMES=2).
// A cycle-count based model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_seg7_scan_mux_n;

   localparam int N  = 4;
   localparam int DV = 8;
   localparam int BL = 2;
   localparam int BF = 2;
   localparam int FR = N * DV;

   logic       clk = 1'b0;
   logic       Rst, wr_en, wr_dp, commit, ERRO;
   logic [1:0] wr_addr;
   logic [4:0] wr_code;
   logic       busy, frame_start, SEG_P;
   logic [6:0] SEGs;
   logic [3:0] SEG_D;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_scan_mux_n #(.N_DIGITS(N), .DIV(DV), .BLANK_CYC(BL), .BLINK_FRAMES(BF)) dut (
      .Clk(clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
      .wr_dp(wr_dp), .commit(commit), .ERRO(ERRO), .busy(busy),
      .frame_start(frame_start), .SEGs(SEGs), .SEG_P(SEG_P), .SEG_D(SEG_D)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [6:0] gl [32];
   int         m_n, m_nb;
   logic [4:0] m_sh [N];
   logic [4:0] m_ac [N];
   logic       m_shdp [N];
   logic       m_acdp [N];
   bit         m_pend, m_valid = 0;
   logic [6:0] e_segs;
   logic       e_p, e_busy, e_fs;
   logic [3:0] e_d;

   always @(posedge clk) begin
      int pre, idx;
      bit bnd, vis;
      m_valid = 1;
      if (Rst) begin
         m_n = 0; m_nb = 0; m_pend = 0;
         for (int i = 0; i < N; i++) begin
            m_sh[i] = 5'h10; m_ac[i] = 5'h10; m_shdp[i] = 0; m_acdp[i] = 0;
         end
         e_segs = 7'h7F; e_p = 1; e_d = 4'hF; e_busy = 0; e_fs = 0;
      end else begin
         pre = m_n % DV;
         idx = (m_n / DV) % N;
         bnd = (m_n % FR) == FR - 1;
         vis = !(ERRO && ((m_nb / BF) % 2 == 1));
         e_segs = 7'h7F; e_p = 1; e_d = 4'hF;
         if (pre >= BL) begin
            e_d = 4'hF & ~(4'b0001 << idx);
            if (vis) begin
               e_segs = gl[m_ac[idx]];
               e_p    = ~m_acdp[idx];
            end
         end
         e_fs = bnd;
         if (bnd && m_pend) begin
            for (int i = 0; i < N; i++) begin
               m_ac[i] = m_sh[i]; m_acdp[i] = m_shdp[i];
            end
         end
         if (wr_en && wr_addr < N) begin
            m_sh[wr_addr] = wr_code; m_shdp[wr_addr] = wr_dp;
         end
         if (commit) m_pend = 1;
         else if (bnd) m_pend = 0;
         e_busy = m_pend;
         if (!ERRO) m_nb = 0;
         else if (bnd) m_nb++;
         m_n++;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("m_segs", SEGs, e_segs);
         chk("m_segp", SEG_P, e_p);
         chk("m_segd", SEG_D, e_d);
         chk("m_busy", busy, e_busy);
         chk("m_fs", frame_start, e_fs);
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_fs();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (frame_start !== 1'b1 && k < 200);
      if (frame_start !== 1'b1) chk("fs_timeout", 0, 1);
   endtask

   task automatic wait_boundary();
      int k = 0;
      while ((m_n % FR) != FR - 1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if ((m_n % FR) != FR - 1) chk("bnd_timeout", 0, 1);
   endtask

   task automatic check_digit(input string nm, input int d, input logic [6:0] s, input logic p);
      logic [3:0] m;
      int k = 0;
      m = 4'hF & ~(4'b0001 << d);
      while (SEG_D !== m && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (SEG_D !== m) chk({nm, "_found"}, 0, 1);
      else begin
         chk({nm, "_segs"}, SEGs, s);
         chk({nm, "_p"}, SEG_P, p);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [4:0] c, input logic d, input logic cm);
      wr_en = 1; wr_addr = a; wr_code = c; wr_dp = d; commit = cm;
      @(negedge clk);
      wr_en = 0; commit = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      for (int i = 0; i < 32; i++) gl[i] = 7'h7F;
      gl[0] = 7'h40; gl[1] = 7'h79; gl[2] = 7'h24; gl[3] = 7'h30;
      gl[4] = 7'h19; gl[5] = 7'h12; gl[6] = 7'h02; gl[7] = 7'h78;
      gl[8] = 7'h00; gl[9] = 7'h10; gl[10] = 7'h08; gl[11] = 7'h03;
      gl[12] = 7'h46; gl[13] = 7'h21; gl[14] = 7'h06; gl[15] = 7'h0E;
      gl[17] = 7'h3F; gl[18] = 7'h06; gl[19] = 7'h2F;
      Rst = 1; wr_en = 0; wr_addr = 0; wr_code = 0; wr_dp = 0; commit = 0; ERRO = 0;

      // 1: reset state and scan timing
      repeat (3) @(negedge clk);
      chk("rst_segs", SEGs, 7'h7F);
      chk("rst_p", SEG_P, 1);
      chk("rst_d", SEG_D, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_fs", frame_start, 0);
      Rst = 0;
      @(negedge clk); chk("rel_d1", SEG_D, 4'hF);
      @(negedge clk); chk("rel_d2", SEG_D, 4'hF);
      @(negedge clk); chk("rel_d3", SEG_D, 4'hE);
      repeat (6) @(negedge clk); chk("rel_d9", SEG_D, 4'hF);
      repeat (2) @(negedge clk); chk("rel_d11", SEG_D, 4'hD);
      wait_fs();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (frame_start !== 1'b1 && k < 40);
      chk("fs_period", k, 32);

      // 2: write a frame and commit
      wr(2'd0, 5'h01, 0, 0);
      wr(2'd1, 5'h02, 1, 0);
      wr(2'd2, 5'h03, 0, 0);
      wr(2'd3, 5'h12, 0, 1);
      chk("t2_busy", busy, 1);
      wait_fs();
      chk("t2_busy_clr", busy, 0);
      check_digit("t2_d0", 0, 7'h79, 1);
      check_digit("t2_d1", 1, 7'h24, 0);
      check_digit("t2_d2", 2, 7'h30, 1);
      check_digit("t2_d3", 3, 7'h06, 1);

      // 3: write without commit, then commit in the boundary cycle
      wr(2'd0, 5'h08, 0, 0);
      for (int f = 0; f < 3; f++) begin
         wait_fs();
         check_digit("t3_hold", 0, 7'h79, 1);
      end
      wait_boundary();
      commit = 1;
      @(negedge clk);
      commit = 0;
      chk("t3_bnd_fs", frame_start, 1);
      chk("t3_busy_kept", busy, 1);
      check_digit("t3_old", 0, 7'h79, 1);
      wait_fs();
      chk("t3_busy_clr", busy, 0);
      check_digit("t3_new", 0, 7'h00, 1);

      // 4: write in the copy cycle of a pending commit
      wait_fs();
      wr(2'd0, 5'h09, 0, 1);
      wait_boundary();
      wr(2'd0, 5'h05, 0, 0);
      chk("t4_busy_clr", busy, 0);
      check_digit("t4_old", 0, 7'h10, 1);
      commit = 1;
      @(negedge clk);
      commit = 0;
      wait_fs();
      check_digit("t4_new", 0, 7'h12, 1);

      // 5: blink
      wait_fs();
      ERRO = 1;
      wait_fs();
      check_digit("t5_vis", 1, 7'h24, 0);
      wait_fs();
      check_digit("t5_dark1", 1, 7'h7F, 1);
      wait_fs();
      check_digit("t5_dark2", 2, 7'h7F, 1);
      ERRO = 0;
      @(negedge clk);
      chk("t5_fall_segs", SEGs, 7'h30);
      chk("t5_fall_d", SEG_D, 4'hB);

      // 6: reset while a commit is pending
      wait_fs();
      wr(2'd2, 5'h11, 0, 1);
      chk("t6_busy", busy, 1);
      repeat (3) @(negedge clk);
      Rst = 1;
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_d", SEG_D, 4'hF);
      Rst = 0;
      wait_fs();
      chk("t6_busy_after", busy, 0);
      check_digit("t6_d0", 0, 7'h7F, 1);
      check_digit("t6_d1", 1, 7'h7F, 1);
      check_digit("t6_d2", 2, 7'h7F, 1);
      check_digit("t6_d3", 3, 7'h7F, 1);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
